// File: rtl/muls_x3y3_seq.sv
// Sequential signed shift-add multiplier: samples x/y, accumulates one
// multiplier bit per cycle (MSB with negative weight), then publishes p/s/rdy.
module muls_x3y3_seq #(
   parameter int X_WIDTH = 3,
   parameter int Y_WIDTH = 3,
   parameter int P_WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [X_WIDTH-1:0] x,
   input  logic [Y_WIDTH-1:0] y,
   output logic [P_WIDTH-1:0] p,
   output logic               s,
   output logic               rdy
);

   localparam int CW = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

   typedef enum logic [1:0] {CAPTURE, STEP, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      step;
   logic [P_WIDTH-1:0] mcand;
   logic [P_WIDTH-1:0] acc;
   logic [P_WIDTH-1:0] addend;
   logic [Y_WIDTH-1:0] y_reg;
   logic               last_step;

   assign addend    = mcand << step;
   assign last_step = (step == CW'(Y_WIDTH-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CAPTURE;
         step  <= '0;
         mcand <= '0;
         y_reg <= '0;
         acc   <= '0;
         p     <= '0;
         s     <= 1'b0;
         rdy   <= 1'b0;
      end else begin
         rdy <= 1'b0;
         case (state)
            CAPTURE: begin
               mcand <= {{(P_WIDTH-X_WIDTH){x[X_WIDTH-1]}}, x};
               y_reg <= y;
               acc   <= '0;
               step  <= '0;
               state <= STEP;
            end
            STEP: begin
               // two's-complement multiplier: the top bit carries weight -2^(Y_WIDTH-1)
               if (y_reg[step])
                  acc <= last_step ? (acc - addend) : (acc + addend);
               if (last_step)
                  state <= DONE;
               else
                  step <= step + CW'(1);
            end
            DONE: begin
               p     <= acc;
               s     <= acc[P_WIDTH-1];
               rdy   <= 1'b1;
               state <= CAPTURE;
            end
            default: state <= CAPTURE;
         endcase
      end
   end

endmodule

// File: tb/tb_muls_x3y3_seq.sv
// Bench for muls_x3y3_seq: directed windows, mid-run reset, exhaustive and random operands.
module tb_muls_x3y3_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] x;
   logic [2:0] y;
   logic [5:0] p;
   logic       s;
   logic       rdy;

   int checks = 0;
   int errors = 0;
   logic [5:0] prev_p = '0;

   muls_x3y3_seq dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .p(p), .s(s), .rdy(rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain signed product of the sampled operands, wrapped to 6 bits.
   function automatic logic [5:0] ref_prod(input logic [2:0] xv, input logic [2:0] yv);
      int xi, yi, prod;
      xi   = (xv[2]) ? int'(xv) - 8 : int'(xv);
      yi   = (yv[2]) ? int'(yv) - 8 : int'(yv);
      prod = xi * yi;
      return prod[5:0];
   endfunction

   // One 5-clock window starting just before a CAPTURE edge; operands are
   // scrambled after capture so the result must come from the sampled values.
   task automatic window(input logic [2:0] xv, input logic [2:0] yv);
      logic [5:0] exp;
      x = xv;
      y = yv;
      exp = ref_prod(xv, yv);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("rdy_low", 8'(rdy), 8'd0);
         chk("p_hold", 8'(p), 8'(prev_p));
         chk("s_hold", 8'(s), 8'(prev_p[5]));
         x = 3'($urandom);
         y = 3'($urandom);
      end
      @(posedge clk); #1;
      chk("p", 8'(p), 8'(exp));
      chk("s", 8'(s), 8'(exp[5]));
      chk("rdy_pulse", 8'(rdy), 8'd1);
      prev_p = exp;
   endtask

   initial begin
      rst = 1'b1;
      x   = 3'd0;
      y   = 3'd0;
      #2;
      chk("rst_p", 8'(p), 8'd0);
      chk("rst_s", 8'(s), 8'd0);
      chk("rst_rdy", 8'(rdy), 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      window(3'd3, 3'd3);
      window(3'd3, 3'd3);
      window(3'd3, 3'd3);
      window(3'b100, 3'b100);
      window(3'b100, 3'd3);
      window(3'd3, 3'b100);
      window(3'd0, 3'b111);
      window(3'b111, 3'b111);
      window(3'd3, 3'd3);

      // reset while the next window sits in STEP1
      x = 3'd2;
      y = 3'd2;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_p", 8'(p), 8'd0);
      chk("midrst_s", 8'(s), 8'd0);
      chk("midrst_rdy", 8'(rdy), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_p = '0;
      window(3'd2, 3'b101);

      for (int i = 0; i < 64; i++)
         window(3'(i >> 3), 3'(i));

      for (int i = 0; i < 20; i++)
         window(3'($urandom), 3'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muls_x3y3_seq.md
Name: muls_x3y3_seq

Overview:
- Sequential signed two's-complement multiplier: 3-bit x times 3-bit y gives a 6-bit product.
- Provides a separate sign flag and a ready strobe.
- Runs continuously: samples operands, computes by shift-add over three step cycles, then publishes the result.
- Intended as the arithmetic core behind an 8-in/8-out tile pinout:
  - inputs: {y, x, rst, clk}
  - outputs: {rdy, s, p}, with p on bits 5:0, s on bit 6, rdy on bit 7.

Parameters:
- X_WIDTH, 3, multiplicand width (signed).
- Y_WIDTH, 3, multiplier width (signed).
- P_WIDTH, 6, product width; must be at least X_WIDTH+Y_WIDTH. Only the defaults are required to be verified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- x  input  3  signed multiplicand, range -4..3.
- y  input  3  signed multiplier, range -4..3.
- p  output  6  signed two's-complement product, registered.
- s  output  1  sign of the published product: 1 when p is negative. Registered; always equals p[5].
- rdy  output  1  result-valid strobe, registered.

Behaviour:
- Reset (async, rst=1):
  - state=CAPTURE; accumulator=0; p=0; s=0; rdy=0.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the first rising edge performs CAPTURE.
- States: CAPTURE -> STEP0 -> STEP1 -> STEP2 -> DONE -> CAPTURE, one state per clock, repeating forever. There is no start input.
- CAPTURE edge:
  - Latch x into a sign-extended 6-bit multiplicand register.
  - Latch y into a 3-bit multiplier register.
  - Clear the accumulator.
  - x/y changes at any other time are ignored until the next CAPTURE.
- STEPi edge (i=0,1):
  - If y_reg[i]=1: acc += mcand << i.
- STEP2 edge:
  - If y_reg[2]=1: acc -= mcand << 2. The multiplier MSB has weight -4.
- All accumulator arithmetic is modulo 2^6. The full range is exact:
  - minimum -12 (3 x -4 or -4 x 3)
  - maximum 16 (-4 x -4)
- DONE edge:
  - p <= acc; s <= acc[5]; rdy <= 1.
- rdy is 1 for exactly one clock period, the one following the DONE edge. It drops to 0 on the next (CAPTURE) edge.
- p and s hold their value until the next DONE edge, so a result stays stable for 5 clocks.
- Latency: operands sampled at edge N appear on p/s, with rdy=1, after edge N+4. Throughput is one result per 5 clocks.
- Reset asserted mid-computation:
  - The in-flight result is discarded.
  - p, s and rdy go to 0 at once.
  - The sequence restarts at CAPTURE.
- Zero product: s=0 (no negative zero).
- No combinational path from x/y to any output.

Test Plan:
- Reset then x=3, y=3 held -> rdy pulses once every 5 clocks; first pulse 5 edges after reset release; p=001001 (9), s=0.
- x=-4 (100), y=-4 (100) -> p=010000 (16), s=0; checks the subtract-on-MSB path and the widest positive result.
- x=-4, y=3, then x=3, y=-4 in the next window -> p=110100 (-12), s=1 both times.
- x=0, y=-1; then x=-1, y=-1 -> p=000000, s=0; then p=000001, s=0.
- Change x/y during STEP1 -> the published product uses the CAPTURE-time operands; new operands appear only in the following window.
- Assert rst during STEP1 after one valid result of 9 -> p=0, s=0, rdy=0 immediately. After release, the 5-cycle sequence restarts and produces the correct product.
- Exhaustive sweep of all 64 (x, y) pairs -> each p equals x*y in 6-bit two's complement, and s=p[5].
